// File: rtl/dmem_pkg.sv
// Shared address map and STATUS layout for the data-memory responder.
// Region limits for the RAM depend on the instance depth, so they come from ram_limit().
package dmem_pkg;

  localparam logic [31:0] RAM_BASE   = 32'h1001_0000;
  localparam logic [31:0] MMIO_BASE  = 32'h1001_F000;
  localparam logic [31:0] MMIO_LIMIT = 32'h1001_F00F;

  localparam logic [11:0] OFF_CYCLE    = 12'h000;
  localparam logic [11:0] OFF_SCRATCH  = 12'h004;
  localparam logic [11:0] OFF_DBG_PUSH = 12'h008;
  localparam logic [11:0] OFF_STATUS   = 12'h00C;

  localparam int STAT_COUNT_W  = 5;
  localparam int STAT_FULL     = 5;
  localparam int STAT_EMPTY    = 6;
  localparam int STAT_OVF      = 7;
  localparam int STAT_ADDR_ERR = 8;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_RAM,
    REG_CYCLE,
    REG_SCRATCH,
    REG_PUSH,
    REG_STATUS
  } region_e;

  function automatic logic [31:0] ram_limit(input int words);
    return RAM_BASE + 32'(4 * words) - 32'd1;
  endfunction

endpackage

// File: rtl/dbg_fifo.sv
// Synchronous debug FIFO with occupancy count; push while full is accepted only
// when a pop frees a slot in the same cycle. DEPTH must be a power of two >= 2.
module dbg_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [DATA_W-1:0]        head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// CPU data-memory responder: zero-latency RAM plus CYCLE/SCRATCH/DBG_PUSH/STATUS MMIO.
// Define DMEM_CYCLE_COUNTER_EN to build the free-running CYCLE counter.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int RAM_WORDS  = 1024,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  input  logic        DMEM_WRITE,
  output logic [31:0] read_data,
  output logic        dbg_valid,
  input  logic        dbg_ready,
  output logic [31:0] dbg_data
);

  localparam int          RAM_AW    = $clog2(RAM_WORDS);
  localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [31:0] RAM_LIMIT = ram_limit(RAM_WORDS);

  logic [31:0]   ram [RAM_WORDS];
  logic [31:0]   word_addr;
  logic [RAM_AW-1:0] ram_idx;
  region_e       region;
  logic [31:0]   cycle_val;
  logic [31:0]   scratch_q;
  logic [31:0]   status;
  logic          overflow_q;
  logic          addr_err_q;
  logic          push;
  logic          pop;
  logic          status_wr;
  logic          ovf_set;
  logic          err_set;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;

  assign word_addr = {address[31:2], 2'b00};
  // RAM base is 64 KiB aligned, so the low address bits are the word offset directly.
  assign ram_idx   = address[RAM_AW+1:2];

  always_comb begin
    region = REG_NONE;
    if (word_addr >= RAM_BASE && word_addr <= RAM_LIMIT) begin
      region = REG_RAM;
    end else if (word_addr >= MMIO_BASE && word_addr <= MMIO_LIMIT) begin
      case (word_addr[11:0])
        OFF_CYCLE:    region = REG_CYCLE;
        OFF_SCRATCH:  region = REG_SCRATCH;
        OFF_DBG_PUSH: region = REG_PUSH;
        OFF_STATUS:   region = REG_STATUS;
        default:      region = REG_NONE;
      endcase
    end
  end

  always_comb begin
    status                     = '0;
    status[STAT_COUNT_W-1:0]   = STAT_COUNT_W'(fifo_count);
    status[STAT_FULL]          = fifo_full;
    status[STAT_EMPTY]         = fifo_empty;
    status[STAT_OVF]           = overflow_q;
    status[STAT_ADDR_ERR]      = addr_err_q;
  end

  always_comb begin
    case (region)
      REG_RAM:     read_data = ram[ram_idx];
      REG_CYCLE:   read_data = cycle_val;
      REG_SCRATCH: read_data = scratch_q;
      REG_STATUS:  read_data = status;
      default:     read_data = '0;
    endcase
  end

  assign push      = DMEM_WRITE && (region == REG_PUSH);
  assign pop       = dbg_valid && dbg_ready;
  assign status_wr = DMEM_WRITE && (region == REG_STATUS);
  assign ovf_set   = push && fifo_full && !pop;
  assign err_set   = DMEM_WRITE && (region == REG_NONE);

  always_ff @(posedge clock) begin
    if (DMEM_WRITE && region == REG_RAM) ram[ram_idx] <= write_data;
  end

  // Sticky flags: a new error in the same cycle as a W1C clear keeps the flag set.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      scratch_q  <= '0;
      overflow_q <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      if (DMEM_WRITE && region == REG_SCRATCH) scratch_q <= write_data;
      overflow_q <= ovf_set | (overflow_q & ~(status_wr & write_data[STAT_OVF]));
      addr_err_q <= err_set | (addr_err_q & ~(status_wr & write_data[STAT_ADDR_ERR]));
    end
  end

`ifdef DMEM_CYCLE_COUNTER_EN
  logic [31:0] cycle_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                               cycle_q <= '0;
    else if (DMEM_WRITE && region == REG_CYCLE) cycle_q <= write_data;
    else                                      cycle_q <= cycle_q + 32'd1;
  end

  assign cycle_val = cycle_q;
`else
  assign cycle_val = '0;
`endif

  dbg_fifo #(
    .DATA_W (32),
    .DEPTH  (FIFO_DEPTH)
  ) u_dbg_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (write_data),
    .pop       (pop),
    .head      (dbg_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign dbg_valid = !fifo_empty;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios with literal
// expectations plus randomized traffic compared against a behavioural model.
`timescale 1ns/1ps
module tb_dmem_responder;

  localparam int          RAM_WORDS = 1024;
  localparam int          DEPTH     = 8;
  localparam logic [31:0] A_RAM     = 32'h1001_0000;
  localparam logic [31:0] A_CYCLE   = 32'h1001_F000;
  localparam logic [31:0] A_SCR     = 32'h1001_F004;
  localparam logic [31:0] A_PUSH    = 32'h1001_F008;
  localparam logic [31:0] A_STAT    = 32'h1001_F00C;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] write_data = '0;
  logic        DMEM_WRITE = 1'b0;
  logic        dbg_ready = 1'b0;
  logic [31:0] read_data;
  logic        dbg_valid;
  logic [31:0] dbg_data;

  always #5 clock = ~clock;

  dmem_responder #(.RAM_WORDS(RAM_WORDS), .FIFO_DEPTH(DEPTH)) dut (
    .clock      (clock),
    .reset      (reset),
    .address    (address),
    .write_data (write_data),
    .DMEM_WRITE (DMEM_WRITE),
    .read_data  (read_data),
    .dbg_valid  (dbg_valid),
    .dbg_ready  (dbg_ready),
    .dbg_data   (dbg_data)
  );

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 0;

  // Behavioural model state
  logic [31:0] m_mem [int];
  logic [31:0] m_q [$];
  logic [31:0] m_cycle;
  logic [31:0] m_scr;
  bit          m_ovf;
  bit          m_ae;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic bit in_ram(input logic [31:0] w);
    return (w >= A_RAM) && (w < A_RAM + 32'(4 * RAM_WORDS));
  endfunction

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    s = 32'(m_q.size());
    if (m_q.size() == DEPTH) s = s + 32'h20;
    if (m_q.size() == 0)     s = s + 32'h40;
    if (m_ovf)               s = s + 32'h80;
    if (m_ae)                s = s + 32'h100;
    return s;
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a, output bit known);
    logic [31:0] w;
    int idx;
    w = {a[31:2], 2'b00};
    known = 1;
    if (in_ram(w)) begin
      idx = int'((w - A_RAM) / 4);
      if (m_mem.exists(idx)) return m_mem[idx];
      known = 0;
      return 32'h0;
    end
    if (w == A_CYCLE) begin
`ifdef DMEM_CYCLE_COUNTER_EN
      return m_cycle;
`else
      return 32'h0;
`endif
    end
    if (w == A_SCR)  return m_scr;
    if (w == A_STAT) return m_status();
    return 32'h0;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_cycle = 0;
    m_scr   = 0;
    m_ovf   = 0;
    m_ae    = 0;
  endtask

  // Advance the model by one clock using the inputs present at the edge.
  task automatic model_clock();
    logic [31:0] w;
    logic [31:0] next_cycle;
    bit pop;
    bit do_push;
    int old_size;
    if (!reset) return;
    w          = {address[31:2], 2'b00};
    old_size   = m_q.size();
    pop        = (old_size != 0) && dbg_ready;
    do_push    = 0;
    next_cycle = m_cycle + 1;
    if (DMEM_WRITE) begin
      if (in_ram(w))            m_mem[int'((w - A_RAM) / 4)] = write_data;
      else if (w == A_CYCLE)    next_cycle = write_data;
      else if (w == A_SCR)      m_scr = write_data;
      else if (w == A_PUSH) begin
        if (old_size < DEPTH || pop) do_push = 1;
        else m_ovf = 1;
      end else if (w == A_STAT) begin
        if (write_data[7]) m_ovf = 0;
        if (write_data[8]) m_ae = 0;
      end else m_ae = 1;
    end
    m_cycle = next_cycle;
    if (pop) void'(m_q.pop_front());
    if (do_push) m_q.push_back(write_data);
  endtask

  always @(negedge clock) begin
    logic [31:0] e;
    bit k;
    if (chk_en) begin
      e = m_read(address, k);
      if (k) check("read_data", read_data, e);
      check("dbg_valid", {31'b0, dbg_valid}, {31'b0, m_q.size() != 0});
      check("dbg_data", dbg_data, (m_q.size() != 0) ? m_q[0] : 32'h0);
    end
  end

  task automatic drive(input logic [31:0] a, input logic [31:0] wd, input logic we, input logic rdy);
    address    = a;
    write_data = wd;
    DMEM_WRITE = we;
    dbg_ready  = rdy;
  endtask

  task automatic tick();
    @(posedge clock);
    model_clock();
    #1;
  endtask

  initial begin
    model_reset();
    drive(32'h0, 32'h0, 1'b0, 1'b0);
    repeat (3) tick();
    chk_en = 1;

    // Reset state
    drive(A_STAT, 32'h0, 1'b0, 1'b0);
    #1 check("reset_status", read_data, 32'h40);
    check("reset_dbg_valid", {31'b0, dbg_valid}, 32'h0);
    reset = 1'b1;
    tick();

    // RAM write / old-value-during-write / unaligned read
    drive(A_RAM + 32'h10, 32'h1111_1111, 1'b1, 1'b0); tick();
    drive(A_RAM + 32'h10, 32'hDEAD_BEEF, 1'b1, 1'b0);
    #1 check("ram_same_cycle_old", read_data, 32'h1111_1111);
    tick();
    drive(32'h1001_0013, 32'h0, 1'b0, 1'b0);
    #1 check("ram_unaligned_read", read_data, 32'hDEAD_BEEF);
    tick();

    // Cycle counter
    drive(A_CYCLE, 32'hFFFF_FFFE, 1'b1, 1'b0); tick();
    drive(A_CYCLE, 32'h0, 1'b0, 1'b0);
`ifdef DMEM_CYCLE_COUNTER_EN
    #1 check("cycle_load", read_data, 32'hFFFF_FFFE); tick();
    #1 check("cycle_max", read_data, 32'hFFFF_FFFF); tick();
    #1 check("cycle_wrap", read_data, 32'h0000_0000); tick();
`else
    for (int i = 0; i < 3; i++) begin
      #1 check("cycle_disabled", read_data, 32'h0);
      tick();
    end
    drive(A_STAT, 32'h0, 1'b0, 1'b0);
    #1 check("cycle_wr_no_err", read_data & 32'h100, 32'h0);
    tick();
`endif

    // FIFO fill with overflow, then drain
    for (int i = 1; i <= 9; i++) begin
      drive(A_PUSH, 32'(i), 1'b1, 1'b0); tick();
    end
    drive(A_STAT, 32'h0, 1'b0, 1'b0);
    #1 check("fill_status", read_data, 32'hA8);
    drive(A_PUSH, 32'h0, 1'b0, 1'b0);
    #1 check("push_reads_zero", read_data, 32'h0);
    for (int i = 1; i <= 8; i++) begin
      drive(A_STAT, 32'h0, 1'b0, 1'b1);
      #1 check("drain_order", dbg_data, 32'(i));
      tick();
    end
    drive(A_STAT, 32'h0, 1'b0, 1'b0);
    #1 check("drain_empty_status", read_data, 32'hC0);
    check("drain_empty_valid", {31'b0, dbg_valid}, 32'h0);
    drive(A_STAT, 32'h80, 1'b1, 1'b0); tick();

    // Push and pop together while full
    for (int i = 1; i <= 8; i++) begin
      drive(A_PUSH, 32'h10 + 32'(i), 1'b1, 1'b0); tick();
    end
    drive(A_STAT, 32'h0, 1'b0, 1'b0);
    #1 check("refill_status", read_data, 32'h28);
    drive(A_PUSH, 32'hA, 1'b1, 1'b1);
    #1 check("full_pushpop_head", dbg_data, 32'h11);
    tick();
    drive(A_STAT, 32'h0, 1'b0, 1'b0);
    #1 check("full_pushpop_status", read_data, 32'h28);
    for (int i = 2; i <= 9; i++) begin
      drive(A_STAT, 32'h0, 1'b0, 1'b1);
      #1 check("pushpop_order", dbg_data, (i == 9) ? 32'hA : 32'h10 + 32'(i));
      tick();
    end
    drive(A_STAT, 32'h0, 1'b0, 1'b0);
    #1 check("pushpop_empty", read_data, 32'h40);

    // Address errors and W1C
    drive(32'h2000_0000, 32'h1234_5678, 1'b1, 1'b0);
    #1 check("bad_reads_zero", read_data, 32'h0);
    tick();
    drive(A_STAT, 32'h0, 1'b0, 1'b0);
    #1 check("addr_err_set", read_data, 32'h140);
    drive(A_STAT, 32'h100, 1'b1, 1'b0); tick();
    drive(32'h3000_0000, 32'h0, 1'b0, 1'b0); tick();
    drive(A_STAT, 32'h0, 1'b0, 1'b0);
    #1 check("addr_err_cleared", read_data, 32'h40);
    drive(32'h2000_0000, 32'h0, 1'b1, 1'b0); tick();
    drive(A_STAT, 32'h100, 1'b1, 1'b0); tick();
    drive(A_RAM + 32'(4 * RAM_WORDS), 32'h0, 1'b1, 1'b0); tick();
    drive(A_STAT, 32'h0, 1'b0, 1'b0);
    #1 check("addr_err_reset_after_w1c", read_data, 32'h140);
    drive(A_STAT, 32'h100, 1'b1, 1'b0); tick();

    // Reset while draining
    for (int i = 1; i <= 5; i++) begin
      drive(A_PUSH, 32'h50 + 32'(i), 1'b1, 1'b0); tick();
    end
    drive(A_STAT, 32'h0, 1'b0, 1'b1); tick();
    drive(A_STAT, 32'h0, 1'b0, 1'b0);
    #1 reset = 1'b0;
    model_reset();
    #1 check("rst_dbg_valid", {31'b0, dbg_valid}, 32'h0);
    check("rst_dbg_data", dbg_data, 32'h0);
    tick();
    tick();
    reset = 1'b1;
    #1 check("rst_status", read_data, 32'h40);
    drive(A_RAM + 32'h10, 32'h0, 1'b0, 1'b0);
    #1 check("rst_ram_kept", read_data, 32'hDEAD_BEEF);
    tick();

    // Randomized traffic
    for (int n = 0; n < 800; n++) begin
      int          sel;
      logic [31:0] a;
      logic        we;
      sel = $urandom_range(0, 11);
      case (sel)
        0, 1, 2, 3: a = A_RAM + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
        4:          a = A_RAM + 32'(4 * (RAM_WORDS - 1));
        5:          a = A_RAM + 32'(4 * RAM_WORDS);
        6:          a = A_SCR;
        7, 8:       a = A_PUSH + 32'($urandom_range(0, 3));
        9:          a = A_STAT;
        10:         a = A_CYCLE;
        default:    a = $urandom;
      endcase
      we = ($urandom_range(0, 2) != 0);
      drive(a, $urandom, we, 1'($urandom_range(0, 2) == 0));
      tick();
    end

    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter RAM_WORDS, default 1024: data RAM depth in 32-bit words.
REQ-002 Parameter FIFO_DEPTH, default 8: debug output FIFO depth, power of two.
REQ-003 Port clock  input  1: single clock; all state updates on the rising edge.
REQ-004 Port reset  input  1: asynchronous, active-low reset.
REQ-005 Port address  input  32: byte address from the CPU MEM stage.
REQ-006 Port write_data  input  32: store data from the CPU.
REQ-007 Port DMEM_WRITE  input  1: write strobe, active high, one access per cycle.
REQ-008 Port read_data  output  32: load data returned to the CPU.
REQ-009 Port dbg_valid  output  1: debug FIFO head valid.
REQ-010 Port dbg_ready  input  1: downstream consumer accepts the head.
REQ-011 Port dbg_data  output  32: debug FIFO head word.

Function
REQ-012 Decode SHALL ignore address[1:0].
- RAM region: 0x1001_0000 to 0x1001_0000+4*RAM_WORDS-1.
- MMIO: 0x1001_F000 CYCLE, 0x1001_F004 SCRATCH, 0x1001_F008 DBG_PUSH, 0x1001_F00C STATUS.
REQ-013 read_data SHALL be combinational from address in the same cycle (zero-latency load), because the CPU samples it at the MEM/WB edge.
REQ-014 Writes SHALL take effect at the rising edge on which DMEM_WRITE=1; a same-cycle read of the written location returns the old value.
REQ-015 CYCLE SHALL increment by 1 every cycle and wrap 0xFFFF_FFFF->0; a write loads write_data, so the next-cycle value is write_data, with no increment that cycle.
REQ-016 SCRATCH SHALL be a plain read/write register.
REQ-017 A write to DBG_PUSH SHALL enqueue write_data; a read of DBG_PUSH returns 0.
REQ-018 STATUS read SHALL return:
- [4:0] FIFO count
- [5] full
- [6] empty
- [7] overflow (sticky)
- [8] addr_err (sticky)
- other bits 0
REQ-019 A write to STATUS SHALL clear bit 7 and/or bit 8 where the write_data bit is 1 (W1C); other bits are ignored.
REQ-020 Debug pop SHALL occur when dbg_valid && dbg_ready; dbg_valid = !empty; dbg_data = head, stable while valid and not popped.
REQ-021 Simultaneous push and pop SHALL both occur, with count unchanged, including when the FIFO is full; push into an empty FIFO with pop is impossible (dbg_valid=0).
REQ-022 Push when full without a pop SHALL drop the word and set overflow.
REQ-023 An access outside all regions SHALL read 0 and ignore the write. If DMEM_WRITE=1, addr_err is set; out-of-range reads do not set it.
REQ-024 If a W1C clear and a new error occur in the same cycle, the set SHALL win.

Reset
REQ-025 While reset=0, the following SHALL be cleared asynchronously:
- CYCLE, SCRATCH, FIFO pointers and count, overflow, addr_err → 0
- dbg_valid → 0
- dbg_data → 0
REQ-026 RAM contents SHALL NOT be affected by reset.
REQ-027 A reset asserted mid-FIFO-drain SHALL discard all queued words.
REQ-028 The first CYCLE increment SHALL occur on the first rising edge after reset deasserts.

Configuration
REQ-029 Macro DMEM_CYCLE_COUNTER_EN:
- Defined: CYCLE behaves per REQ-015.
- Undefined: no counter flops are built; CYCLE reads 0; writes to CYCLE are ignored and do not set addr_err.

Structure
REQ-030 Shared package dmem_pkg SHALL hold:
- region base/limit constants
- the four MMIO offsets
- STATUS bit-position constants
REQ-031 The FIFO SHALL be sub-module dbg_fifo: push/pop/full/empty/count, synchronous, asynchronous active-low reset.

Verification
REQ-032 Bench SHALL cover these directed scenarios:
- RAM: write 0xDEADBEEF to 0x1001_0010, then read 0x1001_0013 → 0xDEADBEEF; same-cycle read during the write → prior value.
- Counter: write 0xFFFF_FFFE to CYCLE → reads 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0000_0000 on consecutive cycles; with the macro undefined → always 0.
- FIFO fill: dbg_ready=0, push 9 words 1..9 → STATUS = count 8, full, overflow set; drain → 1..8 in order, then empty.
- Full push+pop: with the FIFO full, push 0xA and pop in the same cycle → count stays 8, 0xA is last out, overflow unchanged.
- Errors: write to 0x2000_0000 → addr_err=1, reads 0; W1C with 0x100 → clears; W1C coincident with a new bad write → stays 1.
- Reset: assert reset with 5 queued words → dbg_valid=0 immediately, STATUS=0x40 after release, RAM word at 0x1001_0010 retained.
